// File: rtl/mult_row_sequencer.sv
// Sequential unsigned multiplier: one carry-save partial-product row per cycle,
// then a single carry-propagate add to resolve the upper product half.
module mult_row_sequencer #(
    parameter int unsigned WIDTH = 28
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int unsigned CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned PROD_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCUM   = 2'd1,
        S_RESOLVE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [WIDTH-1:0]    sum_q, sum_d;
    logic [WIDTH-1:0]    carry_q, carry_d;
    logic [WIDTH-1:0]    lo_q, lo_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PROD_W-1:0]   product_q, product_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;

    logic [WIDTH-1:0]    pp;
    logic [WIDTH-1:0]    fa_sum;
    logic [WIDTH-1:0]    fa_carry;

    // One full-adder row: partial product folded into the carry-save pair
    always_comb begin
        pp       = a_q & {WIDTH{b_q[cnt_q]}};
        fa_sum   = pp ^ sum_q ^ carry_q;
        fa_carry = (pp & sum_q) | (pp & carry_q) | (sum_q & carry_q);
    end

    // Next-state, datapath updates and registered status flags
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        lo_d        = lo_q;
        cnt_d       = cnt_q;
        product_d   = product_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    sum_d   = '0;
                    carry_d = '0;
                    lo_d    = '0;
                    cnt_d   = '0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                // Retire the row's LSB; the remaining value (fa_sum + 2*fa_carry) >> 1
                // is kept as a shifted sum plus an unshifted carry.
                lo_d    = {fa_sum[0], lo_q[WIDTH-1:1]};
                sum_d   = {1'b0, fa_sum[WIDTH-1:1]};
                carry_d = fa_carry;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = S_RESOLVE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESOLVE: begin
                // Upper half is provably below 2**WIDTH, so the add never overflows
                product_d = {WIDTH'(sum_q + carry_q), lo_q};
                state_d   = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= '0;
            lo_q        <= '0;
            cnt_q       <= '0;
            product_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            lo_q        <= lo_d;
            cnt_q       <= cnt_d;
            product_q   <= product_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign product   = product_q;

endmodule

// File: tb/tb_mult_row_sequencer.sv
// Self-checking bench for mult_row_sequencer: directed table, random operands,
// back-pressure, busy interference and mid-operation reset.
module tb_mult_row_sequencer;

    localparam int W   = 28;
    localparam int LAT = W + 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  product;
    logic            busy;

    int tests  = 0;
    int errors = 0;

    mult_row_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        int             hold;
        bit             interfere;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Entered and left at a negedge with the block in IDLE
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input int hold,
                          input bit interfere, input logic [2*W-1:0] exp);
        int  n;
        bit  seen;
        int  flag_errs;
        chk("in_ready_before_accept", 64'(in_ready), 64'd1);
        a        = ta;
        b        = tb_v;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        seen = 0;
        flag_errs = 0;
        while (n < 4 * LAT && !seen) begin
            if (out_valid) begin
                seen = 1;
            end else begin
                if (in_ready !== 1'b0 || busy !== 1'b1) flag_errs++;
                a         = W'($urandom());
                b         = W'($urandom());
                out_ready = 1'($urandom_range(0, 1));
                if (interfere && n >= 5 && n < 9) begin
                    in_valid = 1'b1;
                    a        = W'(7);
                    b        = W'(7);
                end else begin
                    in_valid = 1'($urandom_range(0, 1));
                end
                step();
                n++;
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("out_valid_seen", 64'(seen), 64'd1);
        chk("latency", 64'(n), 64'(LAT));
        chk("busy_flags_while_working", 64'(flag_errs), 64'd0);
        chk("product", 64'(product), 64'(exp));
        flag_errs = 0;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom_range(0, 1));
            a        = W'($urandom());
            step();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || product !== exp) flag_errs++;
        end
        if (hold > 0) chk("hold_stable", 64'(flag_errs), 64'd0);
        // Release with in_valid high: the leaving edge must not accept
        out_ready = 1'b1;
        in_valid  = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("release_state", {61'd0, in_ready, out_valid, busy}, {61'd0, 3'b100});
    endtask

    initial begin
        logic [W-1:0]   ra, rb;
        logic [2*W-1:0] rexp;
        int             leak;

        vecs[0] = '{a: 28'd3,         b: 28'd5,         hold: 0,  interfere: 0, exp: 56'd15};
        vecs[1] = '{a: 28'hFFFFFFF,   b: 28'hFFFFFFF,   hold: 0,  interfere: 0, exp: 56'hFFFFFFE0000001};
        vecs[2] = '{a: 28'd0,         b: 28'hFFFFFFF,   hold: 0,  interfere: 0, exp: 56'd0};
        vecs[3] = '{a: 28'h8000000,   b: 28'd2,         hold: 10, interfere: 0, exp: 56'h10000000};
        vecs[4] = '{a: 28'h1000,      b: 28'h1000,      hold: 2,  interfere: 1, exp: 56'h1000000};
        vecs[5] = '{a: 28'hFFFFFFF,   b: 28'd1,         hold: 1,  interfere: 1, exp: 56'hFFFFFFF};

        // Reset with in_valid asserted: reset must win
        reset     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        a         = W'(9);
        b         = W'(9);
        step();
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("reset_flags", {61'd0, in_ready, out_valid, busy}, {61'd0, 3'b100});
        chk("reset_product", 64'(product), 64'd0);

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].hold, vecs[i].interfere, vecs[i].exp);
        end

        // Reset twelve edges into an operation discards it
        a        = W'(5);
        b        = W'(9);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 11; i++) step();
        chk("midop_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midop_reset_flags", {61'd0, in_ready, out_valid, busy}, {61'd0, 3'b100});
        chk("midop_reset_product", 64'(product), 64'd0);
        leak = 0;
        for (int i = 0; i < 2 * LAT; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            step();
            if (out_valid !== 1'b0 || in_ready !== 1'b1) leak++;
        end
        out_ready = 1'b0;
        chk("no_out_after_reset", 64'(leak), 64'd0);
        run_op(W'(6), W'(7), 0, 0, 56'd42);

        // Random operands against a plain-arithmetic reference
        for (int i = 0; i < 20; i++) begin
            ra   = W'($urandom());
            rb   = W'($urandom());
            if (i == 0) ra = '1;
            if (i == 1) rb = '0;
            rexp = (2*W)'(ra) * (2*W)'(rb);
            run_op(ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)), rexp);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
